// File: rtl/pipeline_ctrl.sv
// Pipeline control: run/memory-wait/error FSM plus hazard-driven stall, bubble,
// flush and next-PC selection for a classic five-stage pipeline.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       IDrs_i,
    input  logic [4:0]       IDrt_i,
    input  logic             IDbranch_i,
    input  logic             IDjump_i,
    input  logic             IDequal_i,
    input  logic             EXmemread_i,
    input  logic             EXregwrite_i,
    input  logic [4:0]       EXrd_i,
    input  logic             MEMmemread_i,
    input  logic [4:0]       MEMrd_i,
    input  logic             MEMreq_i,
    input  logic             MEMack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_en_o,
    output logic [1:0]       pc_sel_o,
    output logic [1:0]       state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_RUN      = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_ERROR    = 2'b11
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              state;
    logic   [WAIT_W-1:0] wait_cnt;
    logic                miss;
    logic                hold;
    logic                load_use;
    logic                ex_dep;
    logic                mem_dep;
    logic                branch_haz;

    // A miss is an outstanding request without its completion; the ack cycle itself advances.
    assign miss = MEMreq_i && !MEMack_i;
    assign hold = (state == S_IDLE) || (state == S_ERROR) || miss;

    assign load_use = EXmemread_i && (EXrd_i != 5'd0) &&
                      ((EXrd_i == IDrs_i) || (EXrd_i == IDrt_i)) && !IDjump_i;
    assign ex_dep   = EXregwrite_i && (EXrd_i != 5'd0) &&
                      ((EXrd_i == IDrs_i) || (EXrd_i == IDrt_i));
    assign mem_dep  = MEMmemread_i && (MEMrd_i != 5'd0) &&
                      ((MEMrd_i == IDrs_i) || (MEMrd_i == IDrt_i));
    assign branch_haz = IDbranch_i && (ex_dep || mem_dep);

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_en_o     = 1'b0;
        pc_sel_o      = 2'b00;
        if (hold) begin
            pipe_en_o = 1'b0;
        end else if (load_use || branch_haz) begin
            idex_bubble_o = 1'b1;
            pipe_en_o     = 1'b1;
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            pipe_en_o    = 1'b1;
            if (IDjump_i) begin
                pc_sel_o     = 2'b10;
                ifid_flush_o = 1'b1;
            end else if (IDbranch_i && IDequal_i) begin
                pc_sel_o     = 2'b01;
                ifid_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            stall_cnt_o <= '0;
        end else begin
            if ((state == S_RUN || state == S_MEM_WAIT) && !pc_write_o &&
                (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (start_i) state <= S_RUN;
                end
                S_RUN: begin
                    wait_cnt <= '0;
                    if (!start_i)  state <= S_IDLE;
                    else if (miss) state <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (!start_i) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else if (MEMack_i) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_ERROR;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_ERROR;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign state_o = state;
    assign err_o   = (state == S_ERROR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level
// behavioural model of the control rules.
module tb_pipeline_ctrl;

    localparam int TO   = 15;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4:0]    rs = '0, rt = '0, exrd = '0, memrd = '0;
    logic          branch = 0, jump = 0, equal = 0, exmr = 0, exrw = 0, memmr = 0;
    logic          req = 0, ack = 0;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, err;
    logic [1:0]    pc_sel, state;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // model: mode 0 idle, 1 run, 2 waiting on memory, 3 error
    int   m_mode = 0;
    int   m_waited = 0;
    int   m_stalls = 0;
    logic m_pcw = 1'b0;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .IDrs_i(rs), .IDrt_i(rt),
        .IDbranch_i(branch), .IDjump_i(jump), .IDequal_i(equal),
        .EXmemread_i(exmr), .EXregwrite_i(exrw), .EXrd_i(exrd),
        .MEMmemread_i(memmr), .MEMrd_i(memrd),
        .MEMreq_i(req), .MEMack_i(ack),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .pipe_en_o(pipe_en), .pc_sel_o(pc_sel),
        .state_o(state), .err_o(err), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic uses(input logic [4:0] r);
        return (r != 5'd0) && (r == rs || r == rt);
    endfunction

    task automatic check_outputs(input string ph);
        logic e_pcw, e_ifw, e_fl, e_bub, e_pe, stuck, stall;
        logic [1:0] e_sel;
        int e_mode, e_cnt;
        e_pcw = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_pe = 0; e_sel = 2'b00;
        e_mode = rst ? 0 : m_mode;
        e_cnt  = rst ? 0 : m_stalls;
        stuck = rst || m_mode == 0 || m_mode == 3 || (req && !ack);
        stall = (exmr && uses(exrd) && !jump) ||
                (branch && ((exrw && uses(exrd)) || (memmr && uses(memrd))));
        if (!stuck) begin
            e_pe = 1;
            if (stall) begin
                e_bub = 1;
            end else begin
                e_pcw = 1; e_ifw = 1;
                if (jump)                 begin e_sel = 2'b10; e_fl = 1; end
                else if (branch && equal) begin e_sel = 2'b01; e_fl = 1; end
            end
        end
        m_pcw = e_pcw;
        check({ph, ".pc_write"},    32'(pc_write),    32'(e_pcw));
        check({ph, ".ifid_write"},  32'(ifid_write),  32'(e_ifw));
        check({ph, ".ifid_flush"},  32'(ifid_flush),  32'(e_fl));
        check({ph, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        check({ph, ".pipe_en"},     32'(pipe_en),     32'(e_pe));
        check({ph, ".pc_sel"},      32'(pc_sel),      32'(e_sel));
        check({ph, ".state"},       32'(state),       32'(e_mode));
        check({ph, ".err"},         32'(err),         32'(e_mode == 3));
        check({ph, ".stall_cnt"},   32'(stall_cnt),   32'(e_cnt));
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_stalls = 0;
    endtask

    // Advance the model across the coming rising edge with the current inputs.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if ((m_mode == 1 || m_mode == 2) && !m_pcw && m_stalls < SAT) m_stalls++;
        if ((m_mode == 1 || m_mode == 2) && !start) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (req && !ack) begin m_mode = 2; m_waited = 0; end
        end else if (m_mode == 2) begin
            if (ack) m_mode = 1;
            else begin
                m_waited++;
                if (m_waited >= TO) m_mode = 3;
            end
        end
    endtask

    // Inputs are set at a falling edge; outputs checked 1 time unit later.
    task automatic step(input string ph, input bit pulse = 0);
        #1;
        check_outputs(ph);
        if (pulse) begin
            rst = 1'b1;
            #1;
            check_outputs({ph, ".in_rst"});
            rst = 1'b0;
            model_reset();
            #1;
            check_outputs({ph, ".after_rst"});
        end
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet();
        rs = 0; rt = 0; exrd = 0; memrd = 0;
        branch = 0; jump = 0; equal = 0; exmr = 0; exrw = 0; memmr = 0;
        req = 0; ack = 0;
    endtask

    initial begin
        @(negedge clk);
        step("reset");
        step("reset_hold");
        rst = 0;
        step("idle_no_start");
        start = 1;
        step("idle_start");
        step("run_seq");

        // Load-use on rt
        exmr = 1; exrd = 5; rt = 5;
        step("load_use");
        exmr = 0;
        step("load_use_release");

        // Branch depending on a load: two stall cycles, then taken
        quiet(); branch = 1; rs = 8; exmr = 1; exrd = 8; exrw = 1;
        step("br_load_ex");
        exmr = 0; exrw = 0; exrd = 0; memmr = 1; memrd = 8;
        step("br_load_mem");
        memmr = 0; equal = 1;
        step("br_taken");

        // Jump held off by a miss, released on the ack cycle
        quiet(); jump = 1; req = 1;
        for (int i = 0; i < 3; i++) step("jump_miss");
        ack = 1;
        step("jump_ack");
        quiet();
        step("after_ack");

        // Timeout into the terminal error state
        req = 1;
        for (int i = 0; i < TO + 1; i++) step("timeout");
        check("timeout.is_error", 32'(state), 32'd3);
        ack = 1;
        for (int i = 0; i < 3; i++) step("error_sticky");

        // Asynchronous reset pulse while waiting on memory
        rst = 1; quiet();
        step("rst_sync");
        rst = 0;
        step("idle2");
        req = 1;
        step("run_miss");
        step("mem_wait");
        step("wait_pulse", 1);
        quiet();
        check("pulse.run_after_edge", 32'(state), 32'd1);
        step("run_after_pulse");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 59) == 0);
            start  = ($urandom_range(0, 19) != 0);
            rs     = 5'($urandom_range(0, 3));
            rt     = 5'($urandom_range(0, 3));
            exrd   = 5'($urandom_range(0, 3));
            memrd  = 5'($urandom_range(0, 3));
            branch = 1'($urandom_range(0, 1));
            jump   = ($urandom_range(0, 3) == 0);
            equal  = 1'($urandom_range(0, 1));
            exmr   = ($urandom_range(0, 3) == 0);
            exrw   = 1'($urandom_range(0, 1));
            memmr  = ($urandom_range(0, 3) == 0);
            req    = ($urandom_range(0, 2) == 0);
            ack    = req ? ($urandom_range(0, 2) == 0) : 1'b0;
            step("rand", ($urandom_range(0, 79) == 0));
        end

        // Saturation under a continuous hazard
        quiet(); rst = 1; start = 1;
        step("sat_rst");
        rst = 0;
        step("sat_idle");
        exmr = 1; exrd = 3; rs = 3;
        for (int i = 0; i < SAT + 6; i++) step("saturate");
        check("saturate.final", 32'(stall_cnt), 32'(SAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
